// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction-memory writer. Receives a framed little-endian byte
// stream (LEN_LO, LEN_HI, N*4 data bytes, CHK) over a valid/ready byte
// interface, writes each assembled 32-bit word into instruction memory, and
// keeps the core held in reset until a checksum-verified image is loaded.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   start      single-cycle load request (honoured in IDLE/DONE/ERR only)
//   byte_valid byte_data holds a valid byte
//   byte_data  stream byte
//   byte_ready loader accepts a byte this cycle
//   imem_we    instruction-memory write strobe, one cycle per word
//   imem_addr  word address of the write
//   imem_wdata word to write
//   cpu_hold   holds the core in reset
//   done       image loaded and checksum verified
//   error      load aborted (bad length or checksum mismatch)
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    // Memory capacity in words; the largest legal frame length.
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        len_lo_reg;
    logic [ADDR_W:0]   len_reg;
    // One bit wider than the address so a full-capacity load ends without wrap.
    logic [ADDR_W:0]   word_idx_reg;
    logic [1:0]        lane_reg;
    logic [23:0]       word_buf_reg;
    logic [7:0]        acc_reg;

    logic              xfer;
    logic [15:0]       len_in;
    logic              len_ok;
    logic              last_word;

    // byte_ready is a registered copy of "state accepts bytes", so using it
    // here keeps the transfer condition aligned with the current state.
    assign xfer      = byte_valid && byte_ready;
    assign len_in    = {byte_data, len_lo_reg};
    assign len_ok    = (len_in != 16'd0) && ({16'd0, len_in} <= 32'(CAP));
    assign last_word = ((word_idx_reg + (ADDR_W+1)'(1)) == len_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN0;
            end
            LEN0: begin
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                if (xfer) state_next = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (xfer && (lane_reg == 2'd3) && last_word) state_next = CHECK;
            end
            CHECK: begin
                if (xfer) state_next = (byte_data == acc_reg) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and all outputs. Status outputs are registered from the
    // next state so they change in the same cycle as the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            len_lo_reg   <= '0;
            len_reg      <= '0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            word_buf_reg <= '0;
            acc_reg      <= '0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_reg  <= state_next;
            byte_ready <= (state_next == LEN0) || (state_next == LEN1) ||
                          (state_next == DATA) || (state_next == CHECK);
            cpu_hold   <= (state_next != IDLE) && (state_next != DONE);
            done       <= (state_next == DONE);
            error      <= (state_next == ERR);
            imem_we    <= 1'b0;

            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_idx_reg <= '0;
                        lane_reg     <= '0;
                        acc_reg      <= '0;
                    end
                end
                LEN0: begin
                    if (xfer) len_lo_reg <= byte_data;
                end
                LEN1: begin
                    // Only consulted after a legal length, which always fits.
                    if (xfer) len_reg <= len_in[ADDR_W:0];
                end
                DATA: begin
                    if (xfer) begin
                        acc_reg  <= acc_reg ^ byte_data;
                        lane_reg <= lane_reg + 2'd1;
                        case (lane_reg)
                            2'd0: word_buf_reg[7:0]   <= byte_data;
                            2'd1: word_buf_reg[15:8]  <= byte_data;
                            2'd2: word_buf_reg[23:16] <= byte_data;
                            default: begin
                                imem_wdata   <= {byte_data, word_buf_reg};
                                imem_addr    <= word_idx_reg[ADDR_W-1:0];
                                imem_we      <= 1'b1;
                                word_idx_reg <= word_idx_reg + (ADDR_W+1)'(1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int CAPW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Monitor: every write strobe must match the next expected write in order.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {26'd0, imem_addr, imem_wdata}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write", {26'd0, imem_addr, imem_wdata}, {26'd0, e.addr, e.data});
                end
            end
        end
    end

    // Reference model: interpret the frame bytes directly.
    task automatic model(output bit exp_done, output bit exp_err);
        int n;
        logic [7:0] chk;
        n = int'({frame[1], frame[0]});
        exp_done = 1'b0;
        exp_err  = 1'b1;
        if (n < 1 || n > CAPW) return;
        chk = 8'h00;
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = w[ADDR_W-1:0];
            e.data = {frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]};
            for (int k = 0; k < 4; k++) chk ^= frame[2+4*w+k];
            exp_q.push_back(e);
        end
        exp_done = (frame[2+4*n] == chk);
        exp_err  = !exp_done;
    endtask

    task automatic build(input int n, input bit good_chk);
        logic [7:0] chk;
        logic [7:0] b;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        chk = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            chk ^= b;
            frame.push_back(b);
        end
        frame.push_back(good_chk ? chk : (chk ^ 8'(1 + $urandom_range(0, 254))));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", {63'd0, byte_ready}, 64'd1);
        check("start_hold",  {63'd0, cpu_hold},   64'd1);
        check("start_flags", {62'd0, done, error}, 64'd0);
    endtask

    // Call anywhere before a negedge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        bit ok;
        bit rdy;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = st;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            rdy = byte_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input int max_gap, input bit mid_start);
        bit ed;
        bit ee;
        model(ed, ee);
        pulse_start();
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                      mid_start && (i == 6));
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
        check("done",       {63'd0, done},       {63'd0, ed});
        check("error",      {63'd0, error},      {63'd0, ee});
        check("cpu_hold",   {63'd0, cpu_hold},   {63'd0, !ed});
        check("byte_ready", {63'd0, byte_ready}, 64'd0);
        check("writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic load_nominal(input logic [7:0] chk);
        logic [7:0] nom[11];
        nom = '{8'h02, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2, 8'h35};
        frame.delete();
        for (int i = 0; i < 11; i++) frame.push_back(nom[i]);
        frame[10] = chk;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {55'd0, byte_ready, imem_we, cpu_hold, done, error, 4'd0},
              64'd0);
        check("reset_data", {26'd0, imem_addr, imem_wdata}, 64'd0);
        reset = 1'b1;

        // Nominal load, then bad checksum (restart from DONE)
        load_nominal(8'h35);
        run_frame(0, 1'b0);
        load_nominal(8'h36);
        run_frame(0, 1'b0);

        // Length bounds (restart from ERR)
        frame.delete(); frame.push_back(8'h00); frame.push_back(8'h00);
        run_frame(0, 1'b0);
        frame.delete(); frame.push_back(8'h41); frame.push_back(8'h00);
        run_frame(0, 1'b0);
        build(CAPW, 1'b1);
        run_frame(0, 1'b0);

        // Throttled nominal frame with an ignored mid-frame start
        load_nominal(8'h35);
        run_frame(3, 1'b1);

        // Reset mid-DATA
        pulse_start();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check("midrst_outs", {59'd0, byte_ready, imem_we, cpu_hold, done, error}, 64'd0);
        check("midrst_data", {26'd0, imem_addr, imem_wdata}, 64'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        load_nominal(8'h35);
        run_frame(0, 1'b0);

        // Random frames
        for (int r = 0; r < 6; r++) begin
            build(int'($urandom_range(1, 8)), ($urandom_range(0, 3) != 0));
            run_frame(int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
